// File: rtl/baud_generator.sv
// Fractional baud-rate generator.
// Divides clk by a programmable {integer, fraction} divisor to produce a
// one-cycle oversample tick, a bit-rate tick and a bit-rate square wave.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   enable     1 = run, 0 = freeze all counters
//   div_int    new integer divisor (0 is treated as 1)
//   div_frac   new fractional divisor, in units of 1/2^FRAC_WIDTH
//   div_load   strobe, captures div_int/div_frac into the pending register
//   phase_clr  strobe, restarts the divider and oversample phase
//   tick_os    one-cycle pulse at the oversample rate
//   tick_bit   one-cycle pulse on every OVERSAMPLE-th tick_os
//   baud_clk   bit-rate square wave (MSB of the oversample counter)
//   busy_load  high while a captured divisor waits for the next reload
module baud_generator #(
    parameter int unsigned INT_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned RESET_INT  = 27,
    parameter int unsigned RESET_FRAC = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [INT_WIDTH-1:0]  div_int,
    input  logic [FRAC_WIDTH-1:0] div_frac,
    input  logic                  div_load,
    input  logic                  phase_clr,
    output logic                  tick_os,
    output logic                  tick_bit,
    output logic                  baud_clk,
    output logic                  busy_load
);

    localparam int unsigned OS_W      = $clog2(OVERSAMPLE);
    localparam int unsigned RESET_CNT = (RESET_INT == 0) ? 0 : RESET_INT - 1;

    // I' - 1 where I' = max(I, 1)
    function automatic logic [INT_WIDTH-1:0] period_m1(input logic [INT_WIDTH-1:0] i);
        return (i == '0) ? '0 : i - INT_WIDTH'(1);
    endfunction

    logic [INT_WIDTH-1:0]  act_int,  act_int_n;
    logic [FRAC_WIDTH-1:0] act_frac, act_frac_n;
    logic [INT_WIDTH-1:0]  pend_int, pend_int_n;
    logic [FRAC_WIDTH-1:0] pend_frac, pend_frac_n;
    logic                  busy_n;
    logic [INT_WIDTH-1:0]  cnt, cnt_n;
    logic [FRAC_WIDTH-1:0] frac_acc, frac_acc_n;
    logic [OS_W-1:0]       os_cnt, os_cnt_n;
    logic                  tick_os_n, tick_bit_n;

    // Divisor that the next reload or phase restart will use
    logic [INT_WIDTH-1:0]  sel_int;
    logic [FRAC_WIDTH-1:0] sel_frac;
    logic [FRAC_WIDTH:0]   sum;

    assign sel_int  = busy_load ? pend_int  : act_int;
    assign sel_frac = busy_load ? pend_frac : act_frac;
    assign sum      = {1'b0, frac_acc} + {1'b0, sel_frac};
    assign baud_clk = os_cnt[OS_W-1];

    // Next-state for divider, divisor registers and tick outputs
    always_comb begin
        act_int_n   = act_int;
        act_frac_n  = act_frac;
        pend_int_n  = pend_int;
        pend_frac_n = pend_frac;
        busy_n      = busy_load;
        cnt_n       = cnt;
        frac_acc_n  = frac_acc;
        os_cnt_n    = os_cnt;
        tick_os_n   = 1'b0;
        tick_bit_n  = 1'b0;

        if (phase_clr) begin
            // Restart phase, folding in any pending divisor; a same-cycle load is dropped
            act_int_n  = sel_int;
            act_frac_n = sel_frac;
            busy_n     = 1'b0;
            cnt_n      = period_m1(sel_int);
            frac_acc_n = '0;
            os_cnt_n   = '0;
        end else if (!enable) begin
            // Frozen: a load takes effect immediately with a fresh phase
            if (div_load) begin
                act_int_n   = div_int;
                act_frac_n  = div_frac;
                pend_int_n  = div_int;
                pend_frac_n = div_frac;
                busy_n      = 1'b0;
                cnt_n       = period_m1(div_int);
                frac_acc_n  = '0;
            end
        end else begin
            if (cnt == '0) begin
                // Reload edge: emit tick, apply pending divisor, carry stretches next period
                tick_os_n  = 1'b1;
                tick_bit_n = (os_cnt == OS_W'(OVERSAMPLE - 1));
                os_cnt_n   = os_cnt + OS_W'(1);
                frac_acc_n = sum[FRAC_WIDTH-1:0];
                cnt_n      = period_m1(sel_int) + INT_WIDTH'(sum[FRAC_WIDTH]);
                act_int_n  = sel_int;
                act_frac_n = sel_frac;
                busy_n     = 1'b0;
            end else begin
                cnt_n = cnt - INT_WIDTH'(1);
            end
            // Capture after the reload so a coincident load stays pending
            if (div_load) begin
                pend_int_n  = div_int;
                pend_frac_n = div_frac;
                busy_n      = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_int   <= INT_WIDTH'(RESET_INT);
            act_frac  <= FRAC_WIDTH'(RESET_FRAC);
            pend_int  <= INT_WIDTH'(RESET_INT);
            pend_frac <= FRAC_WIDTH'(RESET_FRAC);
            busy_load <= 1'b0;
            cnt       <= INT_WIDTH'(RESET_CNT);
            frac_acc  <= '0;
            os_cnt    <= '0;
            tick_os   <= 1'b0;
            tick_bit  <= 1'b0;
        end else begin
            act_int   <= act_int_n;
            act_frac  <= act_frac_n;
            pend_int  <= pend_int_n;
            pend_frac <= pend_frac_n;
            busy_load <= busy_n;
            cnt       <= cnt_n;
            frac_acc  <= frac_acc_n;
            os_cnt    <= os_cnt_n;
            tick_os   <= tick_os_n;
            tick_bit  <= tick_bit_n;
        end
    end

endmodule
